// File: rtl/multicycle_ctrl.sv
// Purpose : multi-cycle control FSM sequencing IR capture, PC update, ALU, memory and write-back for an RV32I subset.
// Latency : R/I/JAL 4 cycles, LOAD 5, STORE 4, BRANCH 3 (mem_ready in its first cycle); each memory wait adds a cycle.
// Backpressure: FETCH and MEM hold their strobes until mem_ready; after MEM_TIMEOUT waiting cycles the FSM traps.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   en                  run enable, only looked at while in FETCH
//   opcode, funct3      instruction fields from the IR
//   alu_zero            ALU zero flag, used to resolve BEQ/BNE
//   mem_ready           memory access completes this cycle
//   memread, memwrite   memory strobes; iord selects PC (0) or ALU result (1) as address
//   ir_write, pc_write  IR capture / PC load; pc_src 00=PC+4 01=branch 10=jump
//   alu_src_b, alu_op   ALU operand B select and operation class
//   regwr, wb_sel       register write enable and write-back source (00 ALU, 01 mem, 10 PC+4)
//   instret             retired instruction count (wraps)
//   illegal, bus_err    sticky traps; busy low only when idling in FETCH or trapped
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        memread,
    output logic        memwrite,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        regwr,
    output logic [1:0]  wb_sel,
    output logic [31:0] instret,
    output logic        illegal,
    output logic        bus_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Counter value seen in the last permitted waiting cycle.
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT - 1);

    state_t          state, state_nx;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
    logic            waiting;
    logic            retire;
    logic            set_illegal;
    logic            set_bus_err;
    logic            legal;
    logic            br_taken;

    assign legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                   (opcode == OP_STORE) || (opcode == OP_BR) || (opcode == OP_JAL);

    // BEQ taken on zero, BNE taken on non-zero; other funct3 values fall through as not-taken.
    assign br_taken = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);

    always_comb begin
        state_nx    = state;
        memread     = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        alu_src_b   = 1'b0;
        alu_op      = 2'b00;
        regwr       = 1'b0;
        wb_sel      = 2'b00;
        waiting     = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        to_cnt_nx   = '0;

        case (state)
            S_FETCH: begin
                if (en) begin
                    memread = 1'b1;
                    waiting = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_nx = S_DECODE;
                    end else if (to_cnt == TO_LIM) begin
                        set_bus_err = 1'b1;
                        state_nx    = S_TRAP;
                    end
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_nx = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_nx    = S_TRAP;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = 1'b1;
                        state_nx  = S_MEM;
                    end
                    OP_R: begin
                        alu_op   = 2'b10;
                        state_nx = S_WB;
                    end
                    OP_I: begin
                        alu_op    = 2'b11;
                        alu_src_b = 1'b1;
                        state_nx  = S_WB;
                    end
                    OP_BR: begin
                        alu_op = 2'b01;
                        if (br_taken) begin
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        state_nx = S_WB;
                    end
                    default: begin
                        // Opcode changed under us after DECODE accepted it.
                        set_illegal = 1'b1;
                        state_nx    = S_TRAP;
                    end
                endcase
            end
            S_MEM: begin
                iord    = 1'b1;
                waiting = 1'b1;
                if (opcode == OP_STORE) begin
                    memwrite = 1'b1;
                end else begin
                    memread = 1'b1;
                end
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (to_cnt == TO_LIM) begin
                    set_bus_err = 1'b1;
                    state_nx    = S_TRAP;
                end
            end
            S_WB: begin
                regwr = 1'b1;
                if (opcode == OP_LOAD) begin
                    wb_sel = 2'b01;
                end else if (opcode == OP_JAL) begin
                    wb_sel = 2'b10;
                end
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            default: begin
                state_nx = S_TRAP;
            end
        endcase

        // Counter runs only across consecutive not-ready waiting cycles; any other cycle clears it,
        // which gives the clear-on-entry behaviour for both FETCH and MEM.
        if (waiting && !mem_ready && (state_nx != S_TRAP)) begin
            to_cnt_nx = to_cnt + TO_W'(1);
        end

        if (rst) begin
            memread  = 1'b0;
            memwrite = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
            regwr    = 1'b0;
        end
    end

    assign busy = !((state == S_TRAP) || ((state == S_FETCH) && !en));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            to_cnt  <= '0;
            instret <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state  <= state_nx;
            to_cnt <= to_cnt_nx;
            if (retire) begin
                instret <= instret + 32'd1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-instruction cycle scripts derived from the
// instruction-class rules feed an expected-output queue; a negedge monitor pops
// and compares whenever the controller reports busy.
module tb_multicycle_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        memread, memwrite, iord, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        regwr;
    logic [1:0]  wb_sel;
    logic [31:0] instret;
    logic        illegal, bus_err, busy;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .memread(memread), .memwrite(memwrite), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .regwr(regwr), .wb_sel(wb_sel),
        .instret(instret), .illegal(illegal), .bus_err(bus_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [44:0] val;
        logic [44:0] care;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad = 0;
    int   m_cnt = 0;      // model retired count
    int   trap_kind = 0;  // 0 none, 1 illegal, 2 timeout, 3 aborted by reset
    bit   mon_on = 1'b0;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [44:0] pack_dut();
        return {instret, memread, memwrite, iord, ir_write, pc_write, pc_src,
                alu_src_b, alu_op, regwr, wb_sel};
    endfunction

    // Expected cycle record; a negative argument means the field is not checked.
    function automatic exp_t mk(int mr, int mw, int io, int irw, int pcw,
                                int pcs, int asb, int aop, int rw, int wbs);
        exp_t e;
        e.val  = '0;
        e.care = '0;
        e.val[44:13] = m_cnt[31:0];  e.care[44:13] = '1;
        e.val[12]    = mr[0];        e.care[12]    = (mr >= 0);
        e.val[11]    = mw[0];        e.care[11]    = (mw >= 0);
        e.val[10]    = io[0];        e.care[10]    = (io >= 0);
        e.val[9]     = irw[0];       e.care[9]     = (irw >= 0);
        e.val[8]     = pcw[0];       e.care[8]     = (pcw >= 0);
        e.val[7:6]   = pcs[1:0];     e.care[7:6]   = {2{pcs >= 0}};
        e.val[5]     = asb[0];       e.care[5]     = (asb >= 0);
        e.val[4:3]   = aop[1:0];     e.care[4:3]   = {2{aop >= 0}};
        e.val[2]     = rw[0];        e.care[2]     = (rw >= 0);
        e.val[1:0]   = wbs[1:0];     e.care[1:0]   = {2{wbs >= 0}};
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: busy must match whether a record was issued this cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            if (!rst) check("busy", {63'd0, busy}, {63'd0, sb.size() != 0});
            if (rst || sb.size() == 0) begin
                check("strobes_quiet", {59'd0, memread, memwrite, ir_write, pc_write, regwr}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ctrl", {19'd0, pack_dut() & mon_e.care}, {19'd0, mon_e.val & mon_e.care});
            end
        end
    end

    task automatic step_exp(input logic mr, input exp_t e);
        mem_ready = mr;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step_idle(input logic mr);
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_idle(rb());
        rst = 1'b0;
        m_cnt = 0;
        check("rst_instret", {32'd0, instret}, 64'd0);
        check("rst_illegal", {63'd0, illegal}, 64'd0);
        check("rst_bus_err", {63'd0, bus_err}, 64'd0);
    endtask

    task automatic do_trap(input int kind);
        for (int i = 0; i < 20; i++) begin
            en = rb();
            opcode = 7'($urandom);
            step_idle(rb());
        end
        check("trap_illegal", {63'd0, illegal}, {63'd0, kind == 1});
        check("trap_bus_err", {63'd0, bus_err}, {63'd0, kind == 2});
        check("trap_instret", {32'd0, instret}, {32'd0, m_cnt[31:0]});
        do_reset();
    endtask

    function automatic logic [6:0] rand_illegal();
        logic [6:0] o;
        do o = 7'($urandom);
        while (o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111});
        return o;
    endfunction

    // kind: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 random illegal, 7 opcode 1111111.
    // df/dm: not-ready cycles before mem_ready in FETCH/MEM; abort_at: MEM cycle to assert reset in.
    task automatic run_instr(input int kind, input int df, input int dm, input bit az,
                             input logic [2:0] f3, input int abort_at);
        logic [6:0] op;
        bit         taken;
        trap_kind = 0;
        case (kind)
            0:       op = 7'b0110011;
            1:       op = 7'b0010011;
            2:       op = 7'b0000011;
            3:       op = 7'b0100011;
            4:       op = 7'b1100011;
            5:       op = 7'b1101111;
            6:       op = rand_illegal();
            default: op = 7'b1111111;
        endcase
        opcode = op;
        funct3 = f3;
        alu_zero = az;
        en = 1'b1;
        // FETCH
        for (int i = 0; i < df && i < TO; i++) step_exp(1'b0, mk(1, 0, 0, 0, 0, -1, -1, -1, 0, -1));
        if (df >= TO) begin
            trap_kind = 2;
            return;
        end
        step_exp(1'b1, mk(1, 0, 0, 1, 1, 0, -1, -1, 0, -1));
        // DECODE
        step_exp(rb(), mk(0, 0, -1, 0, 0, -1, -1, -1, 0, -1));
        if (kind >= 6) begin
            trap_kind = 1;
            return;
        end
        case (kind)
            0, 1: begin
                step_exp(rb(), mk(0, 0, -1, 0, 0, -1, kind, kind + 2, 0, -1));
                step_exp(rb(), mk(0, 0, -1, 0, 0, -1, -1, -1, 1, 0));
                m_cnt++;
            end
            2, 3: begin
                step_exp(rb(), mk(0, 0, -1, 0, 0, -1, 1, 0, 0, -1));
                for (int i = 0; i < dm && i < TO; i++) begin
                    if (i == abort_at) begin
                        do_reset();
                        trap_kind = 3;
                        return;
                    end
                    step_exp(1'b0, mk(kind == 2, kind == 3, 1, 0, 0, -1, -1, -1, 0, -1));
                end
                if (dm >= TO) begin
                    trap_kind = 2;
                    return;
                end
                step_exp(1'b1, mk(kind == 2, kind == 3, 1, 0, 0, -1, -1, -1, 0, -1));
                if (kind == 2) step_exp(rb(), mk(0, 0, -1, 0, 0, -1, -1, -1, 1, 1));
                m_cnt++;
            end
            4: begin
                taken = ((f3 == 3'b000) && az) || ((f3 == 3'b001) && !az);
                step_exp(rb(), mk(0, 0, -1, 0, taken, taken ? 1 : -1, 0, 1, 0, -1));
                m_cnt++;
            end
            default: begin
                step_exp(rb(), mk(0, 0, -1, 0, 1, 2, -1, -1, 0, -1));
                step_exp(rb(), mk(0, 0, -1, 0, 0, -1, -1, -1, 1, 2));
                m_cnt++;
            end
        endcase
    endtask

    task automatic instr(input int kind, input int df, input int dm, input bit az,
                         input logic [2:0] f3, input int abort_at);
        run_instr(kind, df, dm, az, f3, abort_at);
        if (trap_kind == 1 || trap_kind == 2) do_trap(trap_kind);
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        for (int i = 0; i < n; i++) step_idle(rb());
    endtask

    initial begin
        int kind, df, dm;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        step_idle(1'b0);
        rst = 1'b0;
        check("reset_instret", {32'd0, instret}, 64'd0);
        check("reset_illegal", {63'd0, illegal}, 64'd0);
        check("reset_bus_err", {63'd0, bus_err}, 64'd0);
        idle(3);

        // Directed cases.
        instr(0, 0, 0, 1'b0, 3'b000, -1);   // R-type, no waits
        instr(2, 0, 3, 1'b0, 3'b010, -1);   // LOAD, three MEM waits
        instr(4, 0, 0, 1'b1, 3'b000, -1);   // BEQ taken
        instr(4, 0, 0, 1'b0, 3'b000, -1);   // BEQ not taken
        instr(4, 0, 0, 1'b1, 3'b001, -1);   // BNE not taken
        instr(4, 0, 0, 1'b0, 3'b001, -1);   // BNE taken
        instr(4, 0, 0, 1'b1, 3'b100, -1);   // unsupported funct3: not taken
        instr(5, 1, 0, 1'b0, 3'b000, -1);   // JAL
        instr(1, 2, 0, 1'b0, 3'b000, -1);   // I-type, fetch waits
        instr(3, 0, 0, 1'b0, 3'b010, -1);   // STORE
        check("instret_directed", {32'd0, instret}, {32'd0, m_cnt[31:0]});
        instr(3, 0, TO - 1, 1'b0, 3'b010, -1); // ready on the last allowed MEM cycle
        instr(3, 0, TO, 1'b0, 3'b010, -1);     // MEM timeout
        instr(0, TO - 1, 0, 1'b0, 3'b000, -1); // ready on the last allowed FETCH cycle
        instr(0, TO, 0, 1'b0, 3'b000, -1);     // FETCH timeout
        instr(7, 0, 0, 1'b0, 3'b000, -1);      // opcode 1111111
        instr(0, 0, 0, 1'b0, 3'b000, -1);
        instr(2, 0, 5, 1'b0, 3'b010, 2);       // reset during LOAD MEM
        instr(1, 0, 0, 1'b0, 3'b000, -1);

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            kind = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 5));
            df = ($urandom_range(0, 11) == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(0, 3));
            dm = ($urandom_range(0, 11) == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(0, 3));
            instr(kind, df, dm, rb(), 3'($urandom), ($urandom_range(0, 29) == 0) ? 0 : -1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        check("instret_final", {32'd0, instret}, {32'd0, m_cnt[31:0]});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
